// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, sequencer states and control-word bit indices
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // T1..T6 live in the ring counter; the enum only separates its activity from IDLE/HALT.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALT   = 2'd2
  } seq_state_t;

  localparam int T_W = 6;
  localparam int T1  = 0;
  localparam int T2  = 1;
  localparam int T3  = 2;
  localparam int T4  = 3;
  localparam int T5  = 4;
  localparam int T6  = 5;

  localparam int CW_W        = 13;
  localparam int CW_PC_CP    = 0;
  localparam int CW_PC_EP    = 1;
  localparam int CW_PC_LP    = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OE   = 4;
  localparam int CW_IR_LOAD  = 5;
  localparam int CW_IR_OE    = 6;
  localparam int CW_A_LOAD   = 7;
  localparam int CW_A_OE     = 8;
  localparam int CW_B_LOAD   = 9;
  localparam int CW_ALU_OE   = 10;
  localparam int CW_ALU_SUB  = 11;
  localparam int CW_OUT_LOAD = 12;

  // Opcodes with nothing to do in T5/T6 (JMP, OUT and every NOP).
  function automatic logic is_short(input logic [3:0] op);
    return !(op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_HLT);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T-state shifter with synchronous clear, advance and wrap-to-T1
module ring_counter
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           clear,
  input  logic           advance,
  input  logic           wrap,
  output logic [T_W-1:0] t
);

  always_ff @(posedge clk) begin
    if (clear) begin
      t <= '0;
    end else if (wrap) begin
      t <= {{(T_W-1){1'b0}}, 1'b1};
    end else if (advance) begin
      t <= {t[T_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - T-state sequencer and control-word decode for the 8-bit bus CPU
module controller_sequencer
  import cpu_pkg::*;
#(
  parameter bit EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_cp,
  output logic       pc_ep,
  output logic       pc_lp,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_load,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       instr_done
);

  seq_state_t      state;
  logic [T_W-1:0]  t;
  logic            last;
  logic            hlt_now;
  logic            rc_clear;
  logic            rc_adv;
  logic            rc_wrap;
  logic [CW_W-1:0] cw;

  assign last    = t[T6] | (t[T4] & EARLY_END & is_short(opcode));
  assign hlt_now = t[T4] & (opcode == OP_HLT);

  always_comb begin
    rc_clear = 1'b0;
    rc_adv   = 1'b0;
    rc_wrap  = 1'b0;
    if (rst) begin
      rc_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE:   rc_wrap = run;
        ST_ACTIVE: begin
          if (hlt_now)   rc_clear = 1'b1;
          else if (last) begin
            rc_wrap  = run;
            rc_clear = !run;
          end else       rc_adv = 1'b1;
        end
        default:   rc_clear = 1'b1;
      endcase
    end
  end

  ring_counter u_ring (
    .clk     (clk),
    .clear   (rc_clear),
    .advance (rc_adv),
    .wrap    (rc_wrap),
    .t       (t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (hlt_now)           state <= ST_HALT;
          else if (last && !run) state <= ST_IDLE;
        end
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cw = '0;
    if (state == ST_ACTIVE) begin
      if (t[T1]) begin
        cw[CW_PC_EP]    = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      if (t[T2]) cw[CW_PC_CP] = 1'b1;
      if (t[T3]) begin
        cw[CW_RAM_OE]  = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
      end
      if (t[T4]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_IR_OE]    = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OE] = 1'b1;
            cw[CW_PC_LP] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OE]     = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      if (t[T5]) begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_B_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      if (t[T6] && (opcode == OP_ADD || opcode == OP_SUB)) begin
        cw[CW_ALU_OE]  = 1'b1;
        cw[CW_A_LOAD]  = 1'b1;
        cw[CW_ALU_SUB] = (opcode == OP_SUB);
      end
    end
  end

  assign pc_cp      = cw[CW_PC_CP];
  assign pc_ep      = cw[CW_PC_EP];
  assign pc_lp      = cw[CW_PC_LP];
  assign mar_load   = cw[CW_MAR_LOAD];
  assign ram_oe     = cw[CW_RAM_OE];
  assign ir_load    = cw[CW_IR_LOAD];
  assign ir_oe      = cw[CW_IR_OE];
  assign a_load     = cw[CW_A_LOAD];
  assign a_oe       = cw[CW_A_OE];
  assign b_load     = cw[CW_B_LOAD];
  assign alu_oe     = cw[CW_ALU_OE];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign out_load   = cw[CW_OUT_LOAD];
  assign t_state    = (state == ST_ACTIVE) ? t : '0;
  assign halted     = (state == ST_HALT);
  assign instr_done = (state == ST_ACTIVE) & last;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - self-checking bench for controller_sequencer (EARLY_END 0 and 1)
module tb_controller_sequencer;

  localparam logic [12:0] B_CP  = 13'b1 << 12;
  localparam logic [12:0] B_EP  = 13'b1 << 11;
  localparam logic [12:0] B_PLP = 13'b1 << 10;
  localparam logic [12:0] B_MAR = 13'b1 << 9;
  localparam logic [12:0] B_RAM = 13'b1 << 8;
  localparam logic [12:0] B_IRL = 13'b1 << 7;
  localparam logic [12:0] B_IRO = 13'b1 << 6;
  localparam logic [12:0] B_AL  = 13'b1 << 5;
  localparam logic [12:0] B_AO  = 13'b1 << 4;
  localparam logic [12:0] B_BL  = 13'b1 << 3;
  localparam logic [12:0] B_ALU = 13'b1 << 2;
  localparam logic [12:0] B_SUB = 13'b1 << 1;
  localparam logic [12:0] B_OUT = 13'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run0 = 1'b0;
  logic       run1 = 1'b0;
  logic [3:0] opcode = 4'd0;
  wire [12:0] c0, c1;
  wire [5:0]  t0, t1;
  wire        h0, h1, d0, d1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int ph [2];   // 0 idle, 1..6 = T1..T6, 7 halt

  always #5 clk = ~clk;

  controller_sequencer #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst(rst), .run(run0), .opcode(opcode),
    .pc_cp(c0[12]), .pc_ep(c0[11]), .pc_lp(c0[10]), .mar_load(c0[9]), .ram_oe(c0[8]),
    .ir_load(c0[7]), .ir_oe(c0[6]), .a_load(c0[5]), .a_oe(c0[4]), .b_load(c0[3]),
    .alu_oe(c0[2]), .alu_sub(c0[1]), .out_load(c0[0]),
    .t_state(t0), .halted(h0), .instr_done(d0)
  );

  controller_sequencer #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .opcode(opcode),
    .pc_cp(c1[12]), .pc_ep(c1[11]), .pc_lp(c1[10]), .mar_load(c1[9]), .ram_oe(c1[8]),
    .ir_load(c1[7]), .ir_oe(c1[6]), .a_load(c1[5]), .a_oe(c1[4]), .b_load(c1[3]),
    .alu_oe(c1[2]), .alu_sub(c1[1]), .out_load(c1[0]),
    .t_state(t1), .halted(h1), .instr_done(d1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit short_op(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd15});
  endfunction

  function automatic int next_ph(input int p, input bit early, input bit r, input bit go,
                                 input logic [3:0] op);
    if (r) return 0;
    if (p == 7) return 7;
    if (p == 0) return go ? 1 : 0;
    if (p == 4 && op == 4'd15) return 7;
    if (p == 6 || (p == 4 && early && short_op(op))) return go ? 1 : 0;
    return p + 1;
  endfunction

  function automatic logic [12:0] exp_ctrl(input int p, input logic [3:0] op);
    case (p)
      1: return B_EP | B_MAR;
      2: return B_CP;
      3: return B_RAM | B_IRL;
      4: case (op)
           4'd0, 4'd1, 4'd2: return B_IRO | B_MAR;
           4'd3:             return B_IRO | B_PLP;
           4'd14:            return B_AO | B_OUT;
           default:          return 13'b0;
         endcase
      5: case (op)
           4'd0:       return B_RAM | B_AL;
           4'd1, 4'd2: return B_RAM | B_BL;
           default:    return 13'b0;
         endcase
      6: case (op)
           4'd1:    return B_ALU | B_AL;
           4'd2:    return B_ALU | B_SUB | B_AL;
           default: return 13'b0;
         endcase
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [5:0] exp_t(input int p);
    return (p >= 1 && p <= 6) ? 6'(1 << (p - 1)) : 6'b0;
  endfunction

  function automatic logic exp_done(input int p, input bit early, input logic [3:0] op);
    return (p == 6) || (p == 4 && early && short_op(op));
  endfunction

  always @(posedge clk) begin
    ph[0] = next_ph(ph[0], 1'b0, rst, run0, opcode);
    ph[1] = next_ph(ph[1], 1'b1, rst, run1, opcode);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [12:0] c;
        logic [5:0]  ts;
        logic        h, d;
        c  = (i == 0) ? c0 : c1;
        ts = (i == 0) ? t0 : t1;
        h  = (i == 0) ? h0 : h1;
        d  = (i == 0) ? d0 : d1;
        check($sformatf("dut%0d_outputs", i), {c, ts, h, d},
              {exp_ctrl(ph[i], opcode), exp_t(ph[i]), (ph[i] == 7), exp_done(ph[i], i == 1, opcode)});
        check($sformatf("dut%0d_bus_drivers", i), ($countones({c[11], c[8], c[6], c[4], c[2]}) <= 1), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    tick();
    rst = 1'b0; chk_en = 1'b1;
    run0 = 1'b1; opcode = 4'b0000;
    #2 check("reset_idle", {c0, t0, h0, d0, c1, t1, h1, d1}, 0);

    tick(); #2 check("lda_t1", {c0, t0}, {B_EP | B_MAR, 6'b000001});
    tick(); #2 check("lda_t2", {c0, t0}, {B_CP, 6'b000010});
    tick(); #2 check("lda_t3", {c0, t0}, {B_RAM | B_IRL, 6'b000100});
    tick(); #2 check("lda_t4", {c0, t0}, {B_IRO | B_MAR, 6'b001000});
    tick(); #2 check("lda_t5", {c0, t0}, {B_RAM | B_AL, 6'b010000});
    tick(); #2 check("lda_t6", {c0, t0, d0}, {13'b0, 6'b100000, 1'b1});

    tick(); opcode = 4'b0010;
    repeat (5) tick();
    #2 check("sub_t6", {c0, d0}, {B_ALU | B_SUB | B_AL, 1'b1});

    tick(); opcode = 4'b0001;
    tick(); tick(); run0 = 1'b0;
    tick(); tick(); tick();
    #2 check("add_t6_after_run_drop", {c0, t0, d0}, {B_ALU | B_AL, 6'b100000, 1'b1});
    tick(); #2 check("add_then_idle", {c0, t0}, {13'b0, 6'b0});
    tick(); run0 = 1'b1;
    tick(); #2 check("restart_t1", t0, 6'b000001);

    opcode = 4'b1111;
    tick(); tick(); tick();
    #2 check("hlt_t4", {c0, t0, h0}, {13'b0, 6'b001000, 1'b0});
    tick(); #2 check("hlt_halted", {c0, t0, h0}, {13'b0, 6'b0, 1'b1});
    for (int i = 0; i < 20; i++) begin
      tick(); run0 = 1'($urandom_range(0, 1));
      #2 check("hlt_hold", {c0, t0, h0}, {13'b0, 6'b0, 1'b1});
    end
    rst = 1'b1; run0 = 1'b0;
    tick(); rst = 1'b0;
    #2 check("hlt_reset", {c0, t0, h0, d0}, 0);

    run0 = 1'b1; opcode = 4'b0000;
    repeat (5) tick();
    #2 check("abort_t5", t0, 6'b010000);
    rst = 1'b1;
    tick(); rst = 1'b0; run0 = 1'b0;
    #2 check("abort_idle", {c0, t0, h0, d0}, 0);

    run1 = 1'b1; opcode = 4'b0011;
    repeat (4) tick();
    #2 check("jmp_early_t4", {c1, t1, d1}, {B_IRO | B_PLP, 6'b001000, 1'b1});
    tick(); run1 = 1'b0;
    #2 check("jmp_early_next_t1", t1, 6'b000001);
    repeat (3) tick();
    tick(); #2 check("jmp_early_idle", t1, 6'b0);

    run0 = 1'b1;
    repeat (4) tick();
    #2 check("jmp_full_t4", {c0, d0}, {B_IRO | B_PLP, 1'b0});
    tick(); #2 check("jmp_full_t5", {c0, t0}, {13'b0, 6'b010000});
    tick(); run0 = 1'b0;
    #2 check("jmp_full_t6", {c0, t0, d0}, {13'b0, 6'b100000, 1'b1});
    tick(); #2 check("jmp_full_idle", t0, 6'b0);

    for (int i = 0; i < 1000; i++) begin
      tick();
      rst    = ($urandom_range(0, 63) == 0);
      run0   = ($urandom_range(0, 7) != 0);
      run1   = ($urandom_range(0, 7) != 0);
      opcode = 4'($urandom_range(0, 15));
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
